dma_sync_fifo: RTL

Parametrised single-clock FIFO for the SD host DMA datapath, buffering words between the DMA engine and the SD data-line serialiser. It is the next generation of the DMA buffering FIFO: configurable width and depth, occupancy count, runtime-programmable almost-full and almost-empty thresholds, write acknowledge, registered read-data-valid, synchronous clear, and sticky overflow/underflow error flags.

---
 rtl/dma_sync_fifo.sv | 93 +++++++++
 1 files changed

// File: rtl/dma_sync_fifo.sv
// Single-clock FIFO for the SD host DMA datapath.
// Occupancy is tracked by one level register; status flags are decoded from it.
module dma_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable_write,
  input  logic [WIDTH-1:0] write_data,
  output logic             ack_write,
  input  logic             enable_read,
  output logic [WIDTH-1:0] read_data,
  output logic             read_valid,
  input  logic [AW:0]      af_threshold,
  input  logic [AW:0]      ae_threshold,
  output logic [AW:0]      level,
  output logic             full_out,
  output logic             empty_out,
  output logic             almost_full_out,
  output logic             almost_empty_out,
  output logic             overflow,
  output logic             underflow
);

  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             rd_ok;
  logic             wr_ok;

  assign full_out         = (level == FULL_LEVEL);
  assign empty_out        = (level == '0);
  assign almost_full_out  = (level >= af_threshold);
  assign almost_empty_out = (level <= ae_threshold);

  // A read frees a slot in the same cycle, so a full FIFO still accepts a paired write.
  assign rd_ok = enable_read && !empty_out;
  assign wr_ok = enable_write && (!full_out || rd_ok);

  always_ff @(posedge clock) begin
    if (wr_ok && !clear) begin
      mem[wr_ptr] <= write_data;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      ack_write  <= 1'b0;
      read_valid <= 1'b0;
      read_data  <= '0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
    end else if (clear) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      ack_write  <= 1'b0;
      read_valid <= 1'b0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      ack_write  <= wr_ok;
      read_valid <= rd_ok;
      if (wr_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (rd_ok) begin
        rd_ptr    <= rd_ptr + AW'(1);
        read_data <= mem[rd_ptr];
      end
      if (wr_ok && !rd_ok) begin
        level <= level + (AW+1)'(1);
      end else if (rd_ok && !wr_ok) begin
        level <= level - (AW+1)'(1);
      end
      if (enable_write && !wr_ok) begin
        overflow <= 1'b1;
      end
      if (enable_read && !rd_ok) begin
        underflow <= 1'b1;
      end
    end
  end

endmodule
